// File: rtl/seed_tx_scheduler.sv
// seed_tx_scheduler: buffers 128-bit SEED ciphertext blocks and paces them one at a time into the byte serializer.
// Latency: a queued block seen in IDLE with the serializer idle gets ser_out_en 3 cycles later (LOAD, ARM, LAUNCH).
// Backpressure: blk_ready drops while DEPTH blocks are held; launches wait for ser_busy to fall plus GAP_CYCLES.
// Optional: define SEED_TX_SCHED_TIMEOUT_EN to drop a block whose launch never raises ser_busy (sets err_timeout).
module seed_tx_scheduler #(
    parameter int DEPTH          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     blk_valid,
    input  logic                     blk_first,
    input  logic [127:0]             blk_data,
    output logic                     blk_ready,
    input  logic                     ser_busy,
    output logic [127:0]             ser_seed,
    output logic                     ser_out_en,
    output logic                     ser_start1,
    output logic                     ser_in_en,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     msg_active,
    output logic                     err_timeout
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // One down-counter serves both the launch-acknowledge window and the inter-block gap.
    localparam int CNT_W = (GAP_W > TMO_W) ? GAP_W : TMO_W;

    typedef struct packed {
        logic         first;
        logic [127:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    entry_t             mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    entry_t             head;
    logic               wr_en;
    logic               rd_en;
    state_t             state;
    logic               first_q;
    logic [CNT_W-1:0]   cnt;

    assign blk_ready = (fifo_count != CW'(DEPTH));
    assign wr_en     = blk_valid && blk_ready;
    // The head entry is consumed on the LOAD cycle; it was already copied out on entry to LOAD.
    assign rd_en     = (state == LOAD);
    assign head      = mem[rd_ptr];

    // FIFO storage: data plus the message-first flag, no reset needed on the payload.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{first: blk_first, data: blk_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Launch sequencer: every serializer-facing output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ser_seed   <= '0;
            first_q    <= 1'b0;
            ser_start1 <= 1'b0;
            ser_out_en <= 1'b0;
            ser_in_en  <= 1'b0;
            msg_active <= 1'b0;
            cnt        <= '0;
`ifdef SEED_TX_SCHED_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
        end else begin
            ser_out_en <= 1'b0;
            ser_in_en  <= 1'b0;
            case (state)
                IDLE: begin
                    // A busy serializer (e.g. still finishing a foreign send) holds off the launch.
                    if (fifo_count != '0 && !ser_busy) begin
                        ser_seed   <= head.data;
                        first_q    <= head.first;
                        ser_start1 <= head.first;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    // Strobe start1 in only for a message-first block; this restarts the serializer.
                    ser_in_en <= first_q;
                    state     <= ARM;
                end
                ARM: begin
                    ser_out_en <= 1'b1;
                    if (first_q) begin
                        msg_active <= 1'b1;
                    end
                    state <= LAUNCH;
                end
                LAUNCH: begin
                    cnt   <= CNT_W'(TIMEOUT_CYCLES - 1);
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
`ifdef SEED_TX_SCHED_TIMEOUT_EN
                    if (ser_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == '0) begin
                        // Serializer never acknowledged: drop this block and move on.
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                        if (fifo_count == '0) begin
                            msg_active <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
`else
                    if (ser_busy) begin
                        state <= WAIT_DONE;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!ser_busy) begin
                        cnt   <= CNT_W'(GAP_CYCLES - 1);
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (fifo_count == '0) begin
                            msg_active <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SEED_TX_SCHED_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/seed_tx_scheduler.md
Name: seed_tx_scheduler

Overview:
- Sequences 128-bit SEED ciphertext blocks from the cipher core into the byte serializer, which drives 8-bit bytes plus a load strobe to the RPi 3.
- Buffers blocks in a small FIFO and hands the serializer one block at a time.
- Waits for each transmission to finish, then enforces an inter-block gap.
- Issues a message-start pulse to the serializer at the first block of each message.

Parameters:
- DEPTH, 4: FIFO depth in 128-bit blocks; power of two, 2..16.
- GAP_CYCLES, 16: idle clk cycles between serializer busy falling and the next block launch; minimum 1.
- TIMEOUT_CYCLES, 1024: cycles allowed for ser_busy to rise after a launch (used only with TIMEOUT_EN).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- blk_valid  in  1  cipher block available.
- blk_first  in  1  qualifies blk_valid: block is the first of a new message.
- blk_data  in  128  ciphertext block; byte 0 is [127:120].
- blk_ready  out  1  FIFO can accept a block.
- ser_busy  in  1  serializer is in its send state.
- ser_seed  out  128  block presented to the serializer.
- ser_out_en  out  1  one-cycle launch pulse.
- ser_start1  out  1  level; high while the launched block is a message-first block.
- ser_in_en  out  1  one-cycle strobe that samples ser_start1 into the serializer.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- msg_active  out  1  high from the first launch of a message until the FIFO is empty and the serializer is idle.
- err_timeout  out  1  sticky error flag.

Behaviour:
- Reset:
  - All outputs are 0, except blk_ready = 1.
  - FIFO is empty; state is IDLE.
- FIFO:
  - 129-bit entries: data plus the first flag.
  - Write when blk_valid && blk_ready; blk_ready = (fifo_count != DEPTH).
  - Read pointer advances in the LOAD state.
  - Pointers wrap modulo DEPTH.
  - Simultaneous write and read when full is not possible, because blk_ready is low when full.
  - Simultaneous write and read otherwise: fifo_count is unchanged.
- FSM states: IDLE, LOAD, ARM, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Go to LOAD when fifo_count != 0 and ser_busy == 0.
- LOAD:
  - Latch the head entry into ser_seed and the first-flag register.
  - Pop the FIFO; go to ARM.
- ARM:
  - Drive ser_start1 = first flag.
  - If the flag is set, pulse ser_in_en for this cycle, which restarts the serializer cleanly.
  - Go to LAUNCH.
- LAUNCH:
  - Pulse ser_out_en for exactly one cycle.
  - ser_seed is held stable from LOAD until the next LOAD.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - Go to WAIT_DONE on ser_busy == 1.
- WAIT_DONE:
  - On ser_busy == 0, load the gap counter with GAP_CYCLES-1 and go to GAP.
- GAP:
  - Decrement the counter; at 0 go to IDLE.
- Launch latency: an entry present in IDLE with the serializer idle produces ser_out_en exactly 3 cycles later (LOAD, ARM, LAUNCH).
- ser_start1 deasserts in LOAD of the next non-first block.
- msg_active:
  - Set in LAUNCH when the first flag is 1.
  - Cleared on entering IDLE with fifo_count == 0.
- A blk_first arriving while msg_active does not abort the current block; it takes effect at its own LAUNCH.
- Reset mid-operation:
  - The FIFO is flushed; no further ser_out_en is issued.
  - err_timeout is cleared.
- ser_busy already high in IDLE holds the FSM in IDLE; it does not launch.

Optional Feature:
- SEED_TX_SCHED_TIMEOUT_EN defined:
  - WAIT_BUSY counts cycles.
  - If TIMEOUT_CYCLES elapse without ser_busy, set err_timeout (sticky until reset) and go to IDLE.
  - The block is dropped.
- SEED_TX_SCHED_TIMEOUT_EN undefined:
  - WAIT_BUSY waits indefinitely.
  - err_timeout is tied to 0.

Test Plan:
- Single block: reset, then push one block 0x00112233...EEFF with blk_first=1.
  - ser_out_en pulses once, 3 cycles after entering IDLE with data.
  - ser_in_en pulses in ARM, with ser_start1=1.
  - ser_seed=0x00112233...EEFF.
  - msg_active=1 until busy falls + GAP_CYCLES.
- Back-to-back: push 3 blocks (first=1,0,0); model ser_busy high 100 cycles after each launch.
  - Exactly 3 ser_out_en pulses, each ≥ GAP_CYCLES+3 cycles after the previous busy fall.
  - ser_in_en pulses only on block 1.
- FIFO full: hold ser_busy=1 and push DEPTH+1 blocks.
  - blk_ready drops after 4 writes; fifo_count=4.
  - The 5th block is not accepted until the first pop.
- Wrap-around: push and transmit 10 blocks with DEPTH=4.
  - Output order equals input order; fifo_count returns to 0.
- Reset mid-WAIT_DONE with 2 blocks queued.
  - All outputs return to reset values next cycle; fifo_count=0.
  - No further ser_out_en after ser_busy falls.
- Timeout (macro on, TIMEOUT_CYCLES=1024): launch with ser_busy held 0.
  - err_timeout=1 at cycle 1024 of WAIT_BUSY; FSM is in IDLE.
  - The next queued block launches normally.
